// File: rtl/data_memory_ctrl.sv
// Byte-addressable little-endian data memory for the RV32I MEM stage.
// Supports LB/LH/LW/LBU/LHU and SB/SH/SW, selected by funct3.
// An FSM counts the access latency and drives a busywait handshake.
// Misaligned requests, illegal funct3 and read&&write set access_error.
module data_memory_ctrl #(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned LATENCY     = 5,
  parameter int unsigned ADDR_WIDTH  = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  read,
  input  logic                  write,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic                  busywait,
  output logic                  access_error
);

  localparam int unsigned IDX_W = $clog2(DEPTH_BYTES);
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [2:0]         f3_q, f3_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               is_write_q, is_write_d;
  logic [31:0]        readdata_q, readdata_d;
  logic               err_q, err_d;
  logic [7:0]         mem_q [DEPTH_BYTES];

  logic [7:0]         rb [4];
  logic               legal;
  logic [31:0]        load_val;
  logic [3:0]         we;
  logic               busy_c;

  // Fetch the four bytes starting at the latched index; aligned accesses never wrap.
  always_comb begin
    for (int unsigned k = 0; k < 4; k++) begin
      rb[k] = mem_q[idx_q + IDX_W'(k)];
    end
  end

  // Legality of the latched request: alignment and funct3/direction pairing.
  always_comb begin
    legal = 1'b0;
    case (f3_q)
      3'b000:  legal = 1'b1;
      3'b001:  legal = ~idx_q[0];
      3'b010:  legal = (idx_q[1:0] == 2'b00);
      3'b100:  legal = ~is_write_q;
      3'b101:  legal = ~is_write_q & ~idx_q[0];
      default: legal = 1'b0;
    endcase
  end

  // Load result formatting with sign or zero extension.
  always_comb begin
    load_val = '0;
    case (f3_q)
      3'b000:  load_val = {{24{rb[0][7]}}, rb[0]};
      3'b001:  load_val = {{16{rb[1][7]}}, rb[1], rb[0]};
      3'b010:  load_val = {rb[3], rb[2], rb[1], rb[0]};
      3'b100:  load_val = {24'h000000, rb[0]};
      3'b101:  load_val = {16'h0000, rb[1], rb[0]};
      default: load_val = '0;
    endcase
  end

  // FSM next-state, request capture, access completion and byte write enables.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    f3_d       = f3_q;
    wdata_d    = wdata_q;
    is_write_d = is_write_q;
    readdata_d = readdata_q;
    err_d      = 1'b0;
    we         = '0;
    busy_c     = 1'b0;
    case (state_q)
      IDLE: begin
        busy_c = read ^ write;
        if (read && write) begin
          err_d = 1'b1;
        end else if (read ^ write) begin
          idx_d      = address[IDX_W-1:0];
          f3_d       = funct3;
          wdata_d    = writedata;
          is_write_d = write;
          cnt_d      = CNT_W'(LATENCY - 1);
          state_d    = BUSY;
        end
      end
      BUSY: begin
        busy_c = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = DONE;
          if (legal) begin
            if (is_write_q) begin
              we[0] = 1'b1;
              we[1] = (f3_q == 3'b001) || (f3_q == 3'b010);
              we[2] = (f3_q == 3'b010);
              we[3] = (f3_q == 3'b010);
            end else begin
              readdata_d = load_val;
            end
          end else begin
            err_d = 1'b1;
            if (!is_write_q) begin
              readdata_d = '0;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset forces busywait low even while a request is presented in IDLE.
  always_comb begin
    busywait = busy_c & ~reset;
  end

  assign readdata     = readdata_q;
  assign access_error = err_q;

  // State, captured request, registered outputs and memory array.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      f3_q       <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
      readdata_q <= '0;
      err_q      <= 1'b0;
      for (int unsigned i = 0; i < DEPTH_BYTES; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      f3_q       <= f3_d;
      wdata_q    <= wdata_d;
      is_write_q <= is_write_d;
      readdata_q <= readdata_d;
      err_q      <= err_d;
      for (int unsigned k = 0; k < 4; k++) begin
        if (we[k]) begin
          mem_q[idx_q + IDX_W'(k)] <= wdata_q[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl with hand-computed expectations.
module tb_data_memory_ctrl;

  logic        clock;
  logic        reset;
  logic        read;
  logic        write;
  logic [2:0]  funct3;
  logic [31:0] address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        busywait;
  logic        access_error;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  data_memory_ctrl #(
    .DEPTH_BYTES(1024),
    .LATENCY(5),
    .ADDR_WIDTH(32)
  ) dut (
    .clock(clock),
    .reset(reset),
    .read(read),
    .write(write),
    .funct3(funct3),
    .address(address),
    .writedata(writedata),
    .readdata(readdata),
    .busywait(busywait),
    .access_error(access_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request from IDLE; returns with the DUT back in IDLE, 1 time unit after an edge.
  task automatic do_access(input string tag, input logic r, input logic w,
                           input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic exp_err,
                           input logic [31:0] exp_rd);
    int unsigned cyc;
    read = r; write = w; funct3 = f3; address = a; writedata = wd;
    #1;
    check({tag, "_busy_pre"}, {31'b0, busywait}, 32'd1);
    @(posedge clock); #1;
    cyc = 0;
    while (busywait && cyc < 20) begin
      cyc++;
      @(posedge clock); #1;
    end
    check({tag, "_busy_cycles"}, cyc, 32'd5);
    check({tag, "_err"}, {31'b0, access_error}, {31'b0, exp_err});
    check({tag, "_rd"}, readdata, exp_rd);
    read = 1'b0; write = 1'b0;
    @(posedge clock); #1;
  endtask

  initial begin
    reset = 1'b1; read = 1'b1; write = 1'b0; funct3 = 3'b010;
    address = '0; writedata = '0;
    @(posedge clock); #1;
    check("rst_busy", {31'b0, busywait}, 32'd0);
    check("rst_rd", readdata, 32'd0);
    check("rst_err", {31'b0, access_error}, 32'd0);
    read = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    do_access("sw10",  1'b0, 1'b1, 3'b010, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0);
    do_access("lw10",  1'b1, 1'b0, 3'b010, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF);
    do_access("sb21",  1'b0, 1'b1, 3'b000, 32'h21,  32'hFFFFFF80, 1'b0, 32'hDEADBEEF);
    do_access("lb21",  1'b1, 1'b0, 3'b000, 32'h21,  32'h0,        1'b0, 32'hFFFFFF80);
    do_access("lbu21", 1'b1, 1'b0, 3'b100, 32'h21,  32'h0,        1'b0, 32'h00000080);
    do_access("lw20",  1'b1, 1'b0, 3'b010, 32'h20,  32'h0,        1'b0, 32'h00008000);
    do_access("sh30",  1'b0, 1'b1, 3'b001, 32'h30,  32'hABCD8001, 1'b0, 32'h00008000);
    do_access("lh30",  1'b1, 1'b0, 3'b001, 32'h30,  32'h0,        1'b0, 32'hFFFF8001);
    do_access("lhu30", 1'b1, 1'b0, 3'b101, 32'h30,  32'h0,        1'b0, 32'h00008001);
    do_access("lh31",  1'b1, 1'b0, 3'b001, 32'h31,  32'h0,        1'b1, 32'h0);
    check("lh31_err_clear", {31'b0, access_error}, 32'd0);
    do_access("lw30",  1'b1, 1'b0, 3'b010, 32'h30,  32'h0,        1'b0, 32'h00008001);
    do_access("sw102", 1'b0, 1'b1, 3'b010, 32'h102, 32'hDEADBEEF, 1'b1, 32'h00008001);
    do_access("lw100", 1'b1, 1'b0, 3'b010, 32'h100, 32'h0,        1'b0, 32'h0);
    do_access("lw104", 1'b1, 1'b0, 3'b010, 32'h104, 32'h0,        1'b0, 32'h0);
    do_access("sbu10", 1'b0, 1'b1, 3'b100, 32'h10,  32'h11223344, 1'b1, 32'h0);
    do_access("lw10b", 1'b1, 1'b0, 3'b010, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF);

    // read && write together in IDLE
    read = 1'b1; write = 1'b1; funct3 = 3'b010; address = 32'h10; writedata = 32'h0;
    #1;
    check("rw_busy_pre", {31'b0, busywait}, 32'd0);
    @(posedge clock); #1;
    check("rw_err", {31'b0, access_error}, 32'd1);
    check("rw_busy", {31'b0, busywait}, 32'd0);
    read = 1'b0; write = 1'b0;
    @(posedge clock); #1;
    check("rw_err_clear", {31'b0, access_error}, 32'd0);

    do_access("lw410", 1'b1, 1'b0, 3'b010, 32'h410, 32'h0,        1'b0, 32'hDEADBEEF);

    // Reset during BUSY aborts the store
    read = 1'b0; write = 1'b1; funct3 = 3'b010; address = 32'h40; writedata = 32'h12345678;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("abort_busy_before", {31'b0, busywait}, 32'd1);
    reset = 1'b1;
    #1;
    check("abort_busy", {31'b0, busywait}, 32'd0);
    check("abort_rd", readdata, 32'd0);
    check("abort_err", {31'b0, access_error}, 32'd0);
    write = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    do_access("lw40",  1'b1, 1'b0, 3'b010, 32'h40,  32'h0,        1'b0, 32'h0);
    do_access("lw10c", 1'b1, 1'b0, 3'b010, 32'h10,  32'h0,        1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
Byte-addressable, little-endian data memory with parametrised depth and access latency for the RISC-V pipeline MEM stage. It supports the full RV32I load/store size set (byte/half/word, signed/unsigned loads) selected by funct3, and uses a busywait handshake. Latency is counted in clock cycles by an FSM rather than modelled with delays. Misaligned, illegal and conflicting requests are flagged through an error output.

Parameters:
DEPTH_BYTES, 1024, memory size in bytes; power of two, >= 4
LATENCY, 5, clock edges from request capture to access completion; >= 1
ADDR_WIDTH, 32, width of the byte address input

Ports:
clock  input  1  system clock, all state changes on rising edge
reset  input  1  asynchronous, active-high reset
read  input  1  load request, level, held by requester while busywait high
write  input  1  store request, level, held by requester while busywait high
funct3  input  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU legal for reads only)
address  input  ADDR_WIDTH  byte address
writedata  input  32  store data; B uses [7:0], H uses [15:0]
readdata  output  32  load result, registered
busywait  output  1  stall request to pipeline
access_error  output  1  one-cycle pulse: misaligned, illegal funct3, or read&&write

Behaviour:
- Reset behaviour:
  - Clock and reset are decided: reset is asynchronous and active-high; clock is clock.
  - While reset is high: all DEPTH_BYTES bytes are 0, readdata=0, access_error=0, FSM in IDLE, counter=0.
  - busywait=0 while reset is high, because busywait is forced to 0 by reset.
- Byte index = address[log2(DEPTH_BYTES)-1:0]. Upper address bits are ignored, so addresses wrap modulo DEPTH_BYTES.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - busywait is combinational: 1 when (read XOR write), else 0.
  - At a rising edge with read XOR write: latch address, funct3, writedata and direction; load counter=LATENCY-1; go to BUSY.
  - read&&write at a rising edge: no capture, no memory change, busywait stays 0, access_error=1 for the following cycle, stay IDLE.
- BUSY:
  - busywait=1. Input changes are ignored; latched values are used.
  - Each edge with counter!=0: decrement counter.
  - Edge with counter==0: perform the access, go to DONE.
- Access at completion edge:
  - Legality: word needs addr[1:0]==00; half needs addr[0]==0; byte is always aligned. Write with funct3 100/101, or any 011/11x, is illegal.
  - Legal load:
    - readdata gets little-endian bytes from index upward.
    - B and H sign-extend; BU and HU zero-extend; W is loaded as is.
  - Legal store: write the 1, 2 or 4 low bytes of writedata at index upward. readdata is unchanged.
  - Illegal or misaligned request: memory unchanged, readdata=0 for a load, readdata unchanged for a store, access_error=1 during DONE.
- DONE:
  - busywait=0 and all requests are ignored. This gives the requester one cycle to drop or change read/write.
  - Next edge: go to IDLE.
- Timing: capture at edge E0, completion at edge E(LATENCY), busywait falls right after E(LATENCY), IDLE again after E(LATENCY+1). busywait is high for exactly LATENCY cycles per access.
- A word access cannot straddle the end of memory, because it must be aligned; no wrap occurs within an access.
- Reset asserted in BUSY: the access is aborted, no partial write, and all reset values apply immediately.
- readdata holds its last load value until the next load completes.

Test Plan:
- Reset, then SW 0xDEADBEEF at 0x10, then LW 0x10 -> readdata=0xDEADBEEF; busywait high exactly LATENCY=5 cycles per access; access_error=0.
- SB 0x80 at 0x21, then LB 0x21 -> 0xFFFFFF80; LBU 0x21 -> 0x00000080; LW 0x20 -> 0x00008000.
- SH 0x8001 at 0x30, then LH 0x30 -> 0xFFFF8001; LHU 0x30 -> 0x00008001. LH at 0x31 -> readdata=0, access_error pulses 1 cycle, memory unchanged.
- SW at 0x102 (misaligned) -> access_error pulse and no bytes change; then a store with funct3=100 -> access_error, memory unchanged.
- read=write=1 in IDLE -> busywait=0, access_error=1 next cycle, state stays IDLE. LW at address DEPTH_BYTES+0x10 returns the same data as 0x10 (wrap).
- Start SW 0x12345678 at 0x40, assert reset at cycle 2 of BUSY -> busywait=0 immediately; after release, LW 0x40 -> 0x00000000.
